cpu_param: RTL and testbench
============================

CPU_PARAM -- requirements
Module: cpu_param

Interface
REQ-001 SHALL have parameter DATA_W, default 16, meaning accumulator/data-bus width (DATA_W >= DADDR_W).
REQ-002 SHALL have parameter DADDR_W, default 11, meaning data-address and instruction-operand width.
REQ-003 SHALL have parameter PADDR_W, default 11, meaning program-address width (PADDR_W <= DADDR_W).
REQ-004 SHALL have parameter OPC_W, default 5, meaning opcode width; instruction width is OPC_W+DADDR_W, with the opcode in the MSBs.
REQ-005 SHALL have port clk, input, 1 bit, meaning the single clock; all state changes on its rising edge.
REQ-006 SHALL have port reset, input, 1 bit, meaning synchronous active-high reset.
REQ-007 SHALL have port addr_program, output, PADDR_W bits, meaning PC to program memory.
REQ-008 SHALL have port data, input, OPC_W+DADDR_W bits, meaning the instruction at addr_program, valid in the same cycle (combinational ROM).
REQ-009 SHALL have ports rd and wr, outputs, 1 bit each, meaning data-memory read and write requests; both registered.
REQ-010 SHALL have port addr_data, output, DADDR_W bits, meaning the data-memory address; registered.
REQ-011 SHALL have port in_data, output, DATA_W bits, meaning write data to the RAM; registered.
REQ-012 SHALL have port out_data, input, DATA_W bits, meaning read data from the RAM.
REQ-013 SHALL have port mem_ready, input, 1 bit, meaning the RAM completes the pending rd/wr in this cycle.
REQ-014 SHALL have ports acc, zero, neg and halted, outputs, DATA_W/1/1/1 bits, meaning the accumulator, (acc==0), acc[DATA_W-1], and the HALT state.

Function
REQ-015 SHALL decode the opcodes: 0 HLT; 1 STO (RAM[a]=ACC); 2 LD (ACC=RAM[a]); 3 LDI; 4 ADD; 5 ADDI; 6 SUB; 7 SUBI; 8 AND; 9 OR; 10 XOR (the ALU ops take a memory operand); 11 BEQ; 12 BNE; 13 JMP; all other opcodes act as NOP.
REQ-016 SHALL sign-extend immediates from DADDR_W to DATA_W.
REQ-017 SHALL perform arithmetic modulo 2^DATA_W, discarding carry and borrow.
REQ-018 SHALL implement the FSM states RUN, MEM and HALT.
REQ-019 In RUN, a non-memory instruction SHALL complete in 1 cycle: ACC and PC update at the edge, with PC = PC+1 or the branch target.
REQ-020 Branch target SHALL be operand[PADDR_W-1:0].
REQ-021 BEQ SHALL branch when zero=1; BNE SHALL branch when zero=0; zero is evaluated on the ACC before the edge.
REQ-022 In RUN, a memory instruction (STO, LD, ADD, SUB, AND, OR, XOR) SHALL move to MEM, register rd or wr=1, addr_data=operand and in_data=ACC, and leave PC unchanged.
REQ-023 In MEM, the block SHALL hold rd/wr, addr_data and in_data stable while mem_ready=0, with no timeout.
REQ-024 In MEM with mem_ready=1, the block SHALL sample out_data that cycle, update ACC (LD or ALU op), increment PC, deassert rd/wr at the edge and return to RUN.
REQ-025 A memory instruction SHALL take a minimum of 2 cycles; rd and wr SHALL never be 1 together.
REQ-026 mem_ready SHALL be ignored outside MEM.
REQ-027 HLT SHALL enter HALT; PC and ACC hold, rd=wr=0 and halted=1 until reset.
REQ-028 PC+1 SHALL wrap from 2^PADDR_W-1 to 0.
REQ-029 zero and neg SHALL be combinational from the acc register.

Reset
REQ-030 On reset=1 at an edge: PC=0, ACC=0, rd=wr=0, addr_data=0, in_data=0, state=RUN, halted=0.
REQ-031 Reset SHALL take priority over every other event, including mid-MEM: the pending request is aborted, rd/wr=0 after that edge and no ACC update occurs.

Structure
REQ-032 Package cpu_param_pkg SHALL hold the opcode constants, the FSM state encoding and the ALU-op encoding.
REQ-033 There SHALL be one combinational sub-module, cpu_param_alu (add/sub/and/or/xor/pass), parametrised by DATA_W.
REQ-034 Control (FSM, PC) and datapath (ACC, ALU, memory registers) SHALL share this one module with no further hierarchy.

Verification
REQ-035 Reset: hold reset=1 for 2 cycles -> addr_program=0, acc=0x0000, rd=wr=0, halted=0, zero=1.
REQ-036 Program LDI 5; ADDI -3; STO 0x010; HLT, with mem_ready=1 -> wr=1 for exactly 1 cycle with addr_data=0x010 and in_data=0x0002; then halted=1 and addr_program stays at 3.
REQ-037 LD 0x020 with mem_ready=0 for 3 cycles, then 1 with out_data=0x8000 -> rd=1 for 4 cycles, PC stable, then acc=0x8000, neg=1, PC+1.
REQ-038 LDI -1 (acc=0xFFFF); ADDI 1 -> acc=0x0000, zero=1; then BEQ 0x7FF -> PC=0x7FF; next NOP -> PC wraps to 0x000.
REQ-039 Issue LD with mem_ready=0 and assert reset while rd=1 -> after the edge rd=0, PC=0, acc=0; a late mem_ready=1 has no effect.
REQ-040 LDI 4; SUB a (RAM[a]=4); BNE x -> acc=0, branch not taken (PC+1); repeat with RAM[a]=3 -> acc=0x0001, PC=x.

Source files
------------

// File: rtl/cpu_param_pkg.sv
// Shared encodings for the cpu_param accumulator CPU: opcodes, FSM states, ALU ops.
package cpu_param_pkg;

  localparam int unsigned OP_HLT  = 0;
  localparam int unsigned OP_STO  = 1;
  localparam int unsigned OP_LD   = 2;
  localparam int unsigned OP_LDI  = 3;
  localparam int unsigned OP_ADD  = 4;
  localparam int unsigned OP_ADDI = 5;
  localparam int unsigned OP_SUB  = 6;
  localparam int unsigned OP_SUBI = 7;
  localparam int unsigned OP_AND  = 8;
  localparam int unsigned OP_OR   = 9;
  localparam int unsigned OP_XOR  = 10;
  localparam int unsigned OP_BEQ  = 11;
  localparam int unsigned OP_BNE  = 12;
  localparam int unsigned OP_JMP  = 13;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_MEM  = 2'd1,
    ST_HALT = 2'd2
  } state_e;

  typedef enum logic [2:0] {
    ALU_PASS = 3'd0,
    ALU_ADD  = 3'd1,
    ALU_SUB  = 3'd2,
    ALU_AND  = 3'd3,
    ALU_OR   = 3'd4,
    ALU_XOR  = 3'd5
  } alu_op_e;

endpackage

// File: rtl/cpu_param_alu.sv
// Combinational accumulator ALU; arithmetic wraps modulo 2^DATA_W.
module cpu_param_alu
  import cpu_param_pkg::*;
#(
  parameter int unsigned DATA_W = 16
) (
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  input  alu_op_e           op_i,
  output logic [DATA_W-1:0] y_o
);

  always_comb begin
    y_o = b_i;
    case (op_i)
      ALU_ADD: y_o = a_i + b_i;
      ALU_SUB: y_o = a_i - b_i;
      ALU_AND: y_o = a_i & b_i;
      ALU_OR:  y_o = a_i | b_i;
      ALU_XOR: y_o = a_i ^ b_i;
      default: y_o = b_i;
    endcase
  end

endmodule

// File: rtl/cpu_param.sv
// Accumulator CPU: single-cycle register ops, RUN->MEM handshake for RAM ops, HALT until reset.
module cpu_param
  import cpu_param_pkg::*;
#(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned DADDR_W = 11,
  parameter int unsigned PADDR_W = 11,
  parameter int unsigned OPC_W   = 5
) (
  input  logic                       clk,
  input  logic                       reset,
  output logic [PADDR_W-1:0]         addr_program,
  input  logic [OPC_W+DADDR_W-1:0]   data,
  output logic                       rd,
  output logic                       wr,
  output logic [DADDR_W-1:0]         addr_data,
  output logic [DATA_W-1:0]          in_data,
  input  logic [DATA_W-1:0]          out_data,
  input  logic                       mem_ready,
  output logic [DATA_W-1:0]          acc,
  output logic                       zero,
  output logic                       neg,
  output logic                       halted
);

  localparam int unsigned INSTR_W = OPC_W + DADDR_W;

  state_e               state_q, state_d;
  logic [PADDR_W-1:0]   pc_q, pc_d;
  logic [DATA_W-1:0]    acc_q, acc_d;
  logic                 rd_q, rd_d;
  logic                 wr_q, wr_d;
  logic                 halted_q, halted_d;
  logic [DADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]    wdata_q, wdata_d;
  alu_op_e              mop_q, mop_d;

  logic [31:0]          opc;
  logic [DADDR_W-1:0]   operand;
  logic [DATA_W-1:0]    imm;
  logic [PADDR_W-1:0]   pc_inc;
  logic [PADDR_W-1:0]   target;
  logic [DATA_W-1:0]    alu_b;
  alu_op_e              alu_op;
  logic [DATA_W-1:0]    alu_y;
  logic                 mem_start;
  logic                 mem_read;
  alu_op_e              mem_op;

  assign opc     = 32'(data[INSTR_W-1 -: OPC_W]);
  assign operand = data[DADDR_W-1:0];
  assign imm     = DATA_W'($signed(operand));
  assign pc_inc  = pc_q + PADDR_W'(1);
  assign target  = operand[PADDR_W-1:0];

  cpu_param_alu #(.DATA_W(DATA_W)) u_alu (
    .a_i  (acc_q),
    .b_i  (alu_b),
    .op_i (alu_op),
    .y_o  (alu_y)
  );

  // Next-state: instruction decode in RUN, handshake completion in MEM.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    acc_d     = acc_q;
    rd_d      = rd_q;
    wr_d      = wr_q;
    halted_d  = halted_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    mop_d     = mop_q;
    alu_b     = imm;
    alu_op    = ALU_PASS;
    mem_start = 1'b0;
    mem_read  = 1'b1;
    mem_op    = ALU_PASS;

    case (state_q)
      ST_RUN: begin
        case (opc)
          OP_HLT: begin
            state_d  = ST_HALT;
            halted_d = 1'b1;
          end
          OP_STO: begin mem_start = 1'b1; mem_read = 1'b0; end
          OP_LD:  begin mem_start = 1'b1; mem_op = ALU_PASS; end
          OP_ADD: begin mem_start = 1'b1; mem_op = ALU_ADD;  end
          OP_SUB: begin mem_start = 1'b1; mem_op = ALU_SUB;  end
          OP_AND: begin mem_start = 1'b1; mem_op = ALU_AND;  end
          OP_OR:  begin mem_start = 1'b1; mem_op = ALU_OR;   end
          OP_XOR: begin mem_start = 1'b1; mem_op = ALU_XOR;  end
          OP_LDI: begin acc_d = imm; pc_d = pc_inc; end
          OP_ADDI: begin
            alu_op = ALU_ADD;
            acc_d  = alu_y;
            pc_d   = pc_inc;
          end
          OP_SUBI: begin
            alu_op = ALU_SUB;
            acc_d  = alu_y;
            pc_d   = pc_inc;
          end
          OP_BEQ:  pc_d = (acc_q == '0) ? target : pc_inc;
          OP_BNE:  pc_d = (acc_q != '0) ? target : pc_inc;
          OP_JMP:  pc_d = target;
          default: pc_d = pc_inc;
        endcase
        // PC stays on the memory instruction until the handshake completes.
        if (mem_start) begin
          state_d = ST_MEM;
          rd_d    = mem_read;
          wr_d    = !mem_read;
          addr_d  = operand;
          wdata_d = acc_q;
          mop_d   = mem_op;
        end
      end
      ST_MEM: begin
        alu_b  = out_data;
        alu_op = mop_q;
        if (mem_ready) begin
          if (!wr_q) acc_d = alu_y;
          pc_d    = pc_inc;
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          state_d = ST_RUN;
        end
      end
      default: begin
        rd_d     = 1'b0;
        wr_d     = 1'b0;
        halted_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_RUN;
      pc_q     <= '0;
      acc_q    <= '0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      halted_q <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      mop_q    <= ALU_PASS;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      acc_q    <= acc_d;
      rd_q     <= rd_d;
      wr_q     <= wr_d;
      halted_q <= halted_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      mop_q    <= mop_d;
    end
  end

  assign addr_program = pc_q;
  assign acc          = acc_q;
  assign rd           = rd_q;
  assign wr           = wr_q;
  assign addr_data    = addr_q;
  assign in_data      = wdata_q;
  assign halted       = halted_q;
  assign zero         = (acc_q == '0);
  assign neg          = acc_q[DATA_W-1];

endmodule

// File: tb/tb_cpu_param.sv
// Directed self-checking bench for cpu_param with default parameters.
module tb_cpu_param;

  logic        clk = 1'b0;
  logic        reset;
  logic [10:0] addr_program;
  logic [15:0] data;
  logic        rd, wr;
  logic [10:0] addr_data;
  logic [15:0] in_data;
  logic [15:0] out_data;
  logic        mem_ready;
  logic [15:0] acc;
  logic        zero, neg, halted;

  logic [15:0] rom [0:2047];
  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;
  assign data = rom[addr_program];

  cpu_param dut (
    .clk          (clk),
    .reset        (reset),
    .addr_program (addr_program),
    .data         (data),
    .rd           (rd),
    .wr           (wr),
    .addr_data    (addr_data),
    .in_data      (in_data),
    .out_data     (out_data),
    .mem_ready    (mem_ready),
    .acc          (acc),
    .zero         (zero),
    .neg          (neg),
    .halted       (halted)
  );

  function automatic logic [15:0] ins(input int op, input int opd);
    ins = {5'(op), 11'(opd)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 2048; i++) rom[i] = ins(31, 0);
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    clear_rom();
    mem_ready = 1'b0;
    out_data  = 16'h0;
    apply_reset();
    n_total++;
    if (addr_program !== 11'h000 || acc !== 16'h0000 || rd !== 1'b0 || wr !== 1'b0 ||
        halted !== 1'b0 || zero !== 1'b1)
      $display("FAIL reset_state: pc=%h acc=%h rd=%b wr=%b halted=%b zero=%b, want 000 0000 0 0 0 1",
               addr_program, acc, rd, wr, halted, zero);
    else n_pass++;
  endtask

  task automatic test_store_halt();
    int wr_cnt = 0;
    int rd_cnt = 0;
    logic [10:0] wa = '0;
    logic [15:0] wd = '0;
    clear_rom();
    rom[0] = ins(3, 5);
    rom[1] = ins(5, 11'h7FD);
    rom[2] = ins(1, 11'h010);
    rom[3] = ins(0, 0);
    mem_ready = 1'b1;
    apply_reset();
    for (int i = 0; i < 10; i++) begin
      tick();
      if (wr) begin wr_cnt++; wa = addr_data; wd = in_data; end
      if (rd) rd_cnt++;
    end
    n_total++;
    if (wr_cnt !== 1 || rd_cnt !== 0)
      $display("FAIL sto_pulse: wr_cycles=%0d rd_cycles=%0d, want 1 0", wr_cnt, rd_cnt);
    else n_pass++;
    n_total++;
    if (wa !== 11'h010 || wd !== 16'h0002)
      $display("FAIL sto_payload: addr=%h data=%h, want 010 0002", wa, wd);
    else n_pass++;
    n_total++;
    if (halted !== 1'b1 || addr_program !== 11'd3 || acc !== 16'h0002)
      $display("FAIL halt_hold: halted=%b pc=%h acc=%h, want 1 003 0002", halted, addr_program, acc);
    else n_pass++;
    mem_ready = 1'b0;
  endtask

  task automatic test_mem_wait();
    int rd_cnt = 0;
    int pc_bad = 0;
    clear_rom();
    rom[0] = ins(2, 11'h020);
    mem_ready = 1'b0;
    apply_reset();
    tick();
    n_total++;
    if (rd !== 1'b1 || wr !== 1'b0 || addr_data !== 11'h020)
      $display("FAIL ld_issue: rd=%b wr=%b addr=%h, want 1 0 020", rd, wr, addr_data);
    else n_pass++;
    for (int i = 0; i < 4; i++) begin
      if (rd === 1'b1) rd_cnt++;
      if (addr_program !== 11'h000) pc_bad++;
      if (i == 3) begin mem_ready = 1'b1; out_data = 16'h8000; end
      tick();
    end
    mem_ready = 1'b0;
    n_total++;
    if (rd_cnt !== 4 || pc_bad !== 0)
      $display("FAIL ld_wait: rd_cycles=%0d pc_moves=%0d, want 4 0", rd_cnt, pc_bad);
    else n_pass++;
    n_total++;
    if (rd !== 1'b0 || acc !== 16'h8000 || neg !== 1'b1 || addr_program !== 11'h001)
      $display("FAIL ld_done: rd=%b acc=%h neg=%b pc=%h, want 0 8000 1 001", rd, acc, neg, addr_program);
    else n_pass++;
  endtask

  task automatic test_wrap();
    clear_rom();
    rom[0] = ins(3, 11'h7FF);
    rom[1] = ins(5, 1);
    rom[2] = ins(11, 11'h7FF);
    mem_ready = 1'b0;
    apply_reset();
    tick();
    n_total++;
    if (acc !== 16'hFFFF || neg !== 1'b1)
      $display("FAIL ldi_sext: acc=%h neg=%b, want ffff 1", acc, neg);
    else n_pass++;
    tick();
    n_total++;
    if (acc !== 16'h0000 || zero !== 1'b1)
      $display("FAIL addi_wrap: acc=%h zero=%b, want 0000 1", acc, zero);
    else n_pass++;
    tick();
    n_total++;
    if (addr_program !== 11'h7FF)
      $display("FAIL beq_taken: pc=%h, want 7ff", addr_program);
    else n_pass++;
    tick();
    n_total++;
    if (addr_program !== 11'h000)
      $display("FAIL pc_wrap: pc=%h, want 000", addr_program);
    else n_pass++;
  endtask

  task automatic test_reset_mid_mem();
    clear_rom();
    rom[0] = ins(3, 7);
    rom[1] = ins(2, 11'h020);
    mem_ready = 1'b0;
    apply_reset();
    tick();
    tick();
    n_total++;
    if (rd !== 1'b1 || acc !== 16'h0007 || addr_program !== 11'h001)
      $display("FAIL pre_abort: rd=%b acc=%h pc=%h, want 1 0007 001", rd, acc, addr_program);
    else n_pass++;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_total++;
    if (rd !== 1'b0 || addr_program !== 11'h000 || acc !== 16'h0000)
      $display("FAIL abort: rd=%b pc=%h acc=%h, want 0 000 0000", rd, addr_program, acc);
    else n_pass++;
    rom[0] = ins(31, 0);
    mem_ready = 1'b1;
    out_data  = 16'h1234;
    tick();
    mem_ready = 1'b0;
    n_total++;
    if (rd !== 1'b0 || acc !== 16'h0000 || addr_program !== 11'h001)
      $display("FAIL late_ready: rd=%b acc=%h pc=%h, want 0 0000 001", rd, acc, addr_program);
    else n_pass++;
  endtask

  task automatic test_sub_bne();
    logic [15:0] ram_v [2] = '{16'h0004, 16'h0003};
    logic [15:0] exp_acc [2] = '{16'h0000, 16'h0001};
    logic [10:0] exp_pc [2] = '{11'h003, 11'h100};
    for (int k = 0; k < 2; k++) begin
      clear_rom();
      rom[0] = ins(3, 4);
      rom[1] = ins(6, 11'h030);
      rom[2] = ins(12, 11'h100);
      mem_ready = 1'b1;
      out_data  = ram_v[k];
      apply_reset();
      tick();
      tick();
      n_total++;
      if (rd !== 1'b1 || addr_data !== 11'h030)
        $display("FAIL sub_issue%0d: rd=%b addr=%h, want 1 030", k, rd, addr_data);
      else n_pass++;
      tick();
      n_total++;
      if (acc !== exp_acc[k] || addr_program !== 11'h002)
        $display("FAIL sub_result%0d: acc=%h pc=%h, want %h 002", k, acc, addr_program, exp_acc[k]);
      else n_pass++;
      tick();
      n_total++;
      if (addr_program !== exp_pc[k])
        $display("FAIL bne%0d: pc=%h, want %h", k, addr_program, exp_pc[k]);
      else n_pass++;
    end
    mem_ready = 1'b0;
  endtask

  task automatic test_logic_ops();
    clear_rom();
    rom[0] = ins(3, 11'h0F0);
    rom[1] = ins(8, 11'h040);
    rom[2] = ins(9, 11'h040);
    rom[3] = ins(10, 11'h040);
    mem_ready = 1'b1;
    out_data  = 16'h0FF0;
    apply_reset();
    tick(); tick(); tick();
    n_total++;
    if (acc !== 16'h00F0) $display("FAIL and_op: acc=%h, want 00f0", acc);
    else n_pass++;
    tick(); tick();
    n_total++;
    if (acc !== 16'h0FF0) $display("FAIL or_op: acc=%h, want 0ff0", acc);
    else n_pass++;
    tick(); tick();
    n_total++;
    if (acc !== 16'h0000 || addr_program !== 11'h004)
      $display("FAIL xor_op: acc=%h pc=%h, want 0000 004", acc, addr_program);
    else n_pass++;
    mem_ready = 1'b0;
  endtask

  initial begin
    reset     = 1'b1;
    mem_ready = 1'b0;
    out_data  = 16'h0;
    test_reset();
    test_store_halt();
    test_mem_wait();
    test_wrap();
    test_reset_mid_mem();
    test_sub_bne();
    test_logic_ops();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
